// File: rtl/nanofs_pkg.sv
// nanofs_pkg: constants, state type and header helper shared by the NanoFS
// block writer and reader. A block is an 8-byte little-endian header
// (next logical block, payload length) followed by up to 504 payload bytes,
// zero-filled to the 512-byte SD block size.
package nanofs_pkg;

  localparam int BLOCK_BYTES  = 512;
  localparam int HDR_BYTES    = 8;
  localparam int PAYLOAD_MAX  = BLOCK_BYTES - HDR_BYTES;

  // Header field byte offsets
  localparam int HDR_NEXT_OFS = 0;
  localparam int HDR_LEN_OFS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WR_START,
    ST_SEND,
    ST_WAIT,
    ST_WR_END,
    ST_DONE,
    ST_ERR
  } nanofs_wr_state_t;

  // Header byte at block position pos; 0x00 for any position past the header.
  function automatic logic [7:0] hdr_byte(input logic [31:0] nxt,
                                          input logic [31:0] len,
                                          input logic [9:0]  pos);
    logic [7:0] b;
    b = 8'h00;
    if (pos < 10'(HDR_LEN_OFS))
      b = nxt[{pos[1:0], 3'b000} +: 8];
    else if (pos < 10'(HDR_BYTES))
      b = len[{pos[1:0], 3'b000} +: 8];
    return b;
  endfunction

endpackage

// File: rtl/nanofs_block_buffer.sv
// nanofs_block_buffer: simple dual-port byte RAM holding one block payload.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata registered (one-cycle latency)
module nanofs_block_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nanofs_block_writer.sv
// nanofs_block_writer: packs a producer byte stream into chained NanoFS
// blocks and writes each through the SPI SD controller's single-block
// write interface.
//   clk, reset (sync, active high)
//   start, begin_address, offset          : file control
//   byte_valid/byte_data/byte_last/flush  : producer stream, byte_ready back
//   busy, done, err                       : status
//   spi_w_block, spi_w_byte, spi_data_in, spi_block_addr : to controller
//   spi_busy, spi_err                     : from controller
module nanofs_block_writer
  import nanofs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] begin_address,
  input  logic [31:0] offset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  input  logic        flush,
  output logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic [7:0]  spi_data_in,
  output logic [31:0] spi_block_addr,
  input  logic        spi_busy,
  input  logic        spi_err
);

  localparam logic [8:0] LAST_IDX    = 9'(BLOCK_BYTES - 1);
  localparam logic [8:0] CNT_FULL_M1 = 9'(PAYLOAD_MAX - 1);

  nanofs_wr_state_t state;
  logic [8:0]  cnt, idx;
  logic [31:0] blk_addr;
  logic        last_f;
  logic [7:0]  hdr_q;     // header/pad byte for the current SEND
  logic        sel_buf;   // current SEND takes its byte from the RAM
  logic [7:0]  rd_data;
  logic        accept;
  logic [9:0]  nxt_pos;   // block position the next SEND will transmit
  logic [31:0] next_ptr;
  logic [7:0]  hdr_nxt;
  logic        sel_nxt;
  logic        spi_phase;

  assign accept         = (state == ST_FILL) && byte_valid && byte_ready;
  assign next_ptr       = last_f ? 32'd0 : blk_addr + 32'd1;
  assign nxt_pos        = (state == ST_WAIT) ? {1'b0, idx} + 10'd1 : 10'd0;
  assign hdr_nxt        = hdr_byte(next_ptr, {23'b0, cnt}, nxt_pos);
  assign sel_nxt        = (nxt_pos >= 10'(HDR_BYTES)) &&
                          (nxt_pos < {1'b0, cnt} + 10'(HDR_BYTES));
  assign spi_block_addr = blk_addr + offset;
  // RAM output is already registered, so the byte shows in the SEND cycle
  // itself, aligned with the spi_w_byte pulse.
  assign spi_data_in    = sel_buf ? rd_data : hdr_q;
  assign spi_phase      = (state == ST_WR_START) || (state == ST_SEND) ||
                          (state == ST_WAIT) || (state == ST_WR_END);

  // Read address is the RAM slot of the next position, presented in the
  // cycle that leaves WR_START/WAIT.
  nanofs_block_buffer #(.DEPTH(BLOCK_BYTES), .AW(9)) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (cnt),
    .wdata (byte_data),
    .raddr (nxt_pos[8:0] - 9'd8),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      blk_addr    <= '0;
      last_f      <= 1'b0;
      hdr_q       <= 8'h00;
      sel_buf     <= 1'b0;
      byte_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      spi_w_block <= 1'b0;
      spi_w_byte  <= 1'b0;
    end else begin
      spi_w_byte <= 1'b0;
      if (spi_phase && spi_err) begin
        // Abandon the block; controller strobes go low at once.
        state       <= ST_ERR;
        err         <= 1'b1;
        busy        <= 1'b0;
        byte_ready  <= 1'b0;
        spi_w_block <= 1'b0;
        sel_buf     <= 1'b0;
        hdr_q       <= 8'h00;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state      <= ST_FILL;
            blk_addr   <= begin_address;
            cnt        <= '0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
          ST_FILL: begin
            if (byte_valid) begin
              cnt <= cnt + 9'd1;
              if (byte_last || cnt == CNT_FULL_M1) begin
                state       <= ST_WR_START;
                last_f      <= byte_last;
                byte_ready  <= 1'b0;
                spi_w_block <= 1'b1;
              end
            end else if (flush) begin
              state       <= ST_WR_START;
              last_f      <= 1'b1;
              byte_ready  <= 1'b0;
              spi_w_block <= 1'b1;
            end
          end
          ST_WR_START: if (!spi_busy) begin
            idx        <= '0;
            state      <= ST_SEND;
            spi_w_byte <= 1'b1;
            hdr_q      <= hdr_nxt;
            sel_buf    <= sel_nxt;
          end
          ST_SEND: state <= ST_WAIT;
          ST_WAIT: if (!spi_busy) begin
            if (idx == LAST_IDX) begin
              state       <= ST_WR_END;
              spi_w_block <= 1'b0;
              sel_buf     <= 1'b0;
              hdr_q       <= 8'h00;
            end else begin
              idx        <= idx + 9'd1;
              state      <= ST_SEND;
              spi_w_byte <= 1'b1;
              hdr_q      <= hdr_nxt;
              sel_buf    <= sel_nxt;
            end
          end
          ST_WR_END: if (!spi_busy) begin
            if (last_f) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= ST_FILL;
              blk_addr   <= blk_addr + 32'd1;
              cnt        <= '0;
              byte_ready <= 1'b1;
            end
          end
          ST_DONE: if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
          ST_ERR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nanofs_block_writer.md
# nanofs_block_writer

Writer side of the NanoFS block-chain format: accepts a byte stream from a producer, packs it into 512-byte SD blocks with an 8-byte header (next-block pointer, payload length), and writes each block through the SPI SD controller's single-block write interface. Blocks are allocated consecutively from `begin_address`. The last block carries next pointer 0. The resulting chain is directly readable by the NanoFS multiblock loader.

## Interface
- `BLOCK_BYTES`, 512, SD block size in bytes; the payload capacity is `BLOCK_BYTES-8` (504).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; sampled in IDLE to begin a file.
- `begin_address` in 32: logical address of the first block; sampled on start.
- `offset` in 32: partition offset added to every physical address; not stored in headers.
- `byte_valid` in 1: producer byte strobe.
- `byte_data` in 8: payload byte.
- `byte_last` in 1: qualified by `byte_valid`; marks the final byte of the file.
- `flush` in 1: in FILL with no `byte_valid`, closes the file with the bytes buffered so far.
- `byte_ready` out 1: a byte is accepted when `byte_valid & byte_ready`.
- `busy` out 1: high from start until DONE or ERR.
- `done` out 1: level in DONE.
- `err` out 1: level in ERR.
- `spi_w_block` out 1: held high for a whole block write.
- `spi_w_byte` out 1: one-cycle pulse; the controller loads `spi_data_in`.
- `spi_data_in` out 8: registered byte to the controller.
- `spi_block_addr` out 32: physical block address, equal to `blk_addr + offset`.
- `spi_busy` in 1, `spi_err` in 1: controller status.

## Operation
- Header layout, little-endian:
  - bytes 0..3 are the next logical block address, or 0 for the last block.
  - bytes 4..7 are the payload length L (0..504).
  - bytes 8..8+L-1 are payload; the remaining bytes up to 511 are 0x00.
- States:
  - IDLE: `start` → FILL. Loads `blk_addr <= begin_address` and clears `cnt`.
  - FILL: `byte_ready=1`. On accept, writes buffer[`cnt`] and increments `cnt`.
    - `byte_last` accepted → WR_START with `last_f=1`.
    - Accept making `cnt==504` → WR_START with `last_f=0`.
    - `flush` with no valid byte → WR_START with `last_f=1`; `cnt` may be 0.
  - WR_START: `spi_w_block=1`. Waits for `spi_busy==0`, sets `idx=0`, → SEND.
  - SEND: pulses `spi_w_byte` with `spi_data_in = byte(idx)` → WAIT.
  - WAIT: waits for `spi_busy==0`.
    - If `idx==511` → WR_END.
    - Otherwise increments `idx` and → SEND.
  - WR_END: drops `spi_w_block` and waits for `spi_busy==0`.
    - If `last_f` → DONE.
    - Otherwise increments `blk_addr`, clears `cnt`, → FILL.
  - DONE: `done=1`, `busy=0`. `start` low → IDLE.
  - ERR: `err=1`, `busy=0`. Sticky until `reset`.
- Byte source mux:
  - `idx` 0..3 gives byte k of `next`, where `next = last_f ? 0 : blk_addr+1`.
  - `idx` 4..7 gives byte k of `{23'b0,cnt}`.
  - `idx` 8..cnt+7 gives buffer[`idx`-8].
  - Otherwise 0x00.
- `spi_err` sampled high in any WR_*/SEND/WAIT state → ERR. SPI strobes go low immediately and the block is abandoned.
- Simultaneous `flush` and `byte_valid`: the byte is accepted and `flush` is ignored that cycle.
- `reset` mid-block: returns to IDLE with all outputs at reset values. The partially written block is undefined on media.

## Timing
- Reset values:
  - `byte_ready`, `busy`, `done`, `err`, `spi_w_block`, `spi_w_byte` = 0.
  - `spi_data_in` = 0x00.
  - `spi_block_addr` = `offset`, because `blk_addr` = 0.
- Buffer read has one-cycle latency. The read address is presented in the cycle before SEND (WR_START exit / WAIT exit), so the SEND cycle drives valid data.
- Throughput: one payload byte per cycle in FILL.
- Per block: 512 × (2 + controller busy cycles) + WR_START/WR_END overhead.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `byte_ready` drops the cycle after the accepting edge that causes the WR_START transition.

## Structure
- `nanofs_pkg` holds:
  - `BLOCK_BYTES`, `HDR_BYTES=8`, `PAYLOAD_MAX=504`;
  - the state enum `nanofs_wr_state_t`;
  - header offset constants, shared with the reader.
- Sub-module `nanofs_block_buffer`: 512×8 simple dual-port RAM, one write port and one registered read port.
- The FSM, counters (`cnt` 9-bit, `idx` 9-bit, `blk_addr` 32-bit) and the header mux live in the top level.

## Test plan
- `begin_address=0x10`, `offset=0x2000`, 3 bytes AA BB CC with `last` on CC → one write to 0x2010. Bytes are 00 00 00 00 03 00 00 00 AA BB CC, zero-filled to 512. `done=1`.
- 600 bytes (value = i mod 256), `begin_address=5`, `offset=0`:
  - block 5 has next=6, L=504;
  - block 6 has next=0, L=96;
  - data is continuous across the boundary.
- Exactly 504 bytes with `last` on byte 504 → a single block, next=0, L=504, no second write.
- `flush` with no bytes after start → one block with next=0, L=0 and all-zero payload.
- `spi_err` pulsed during byte 100 of a block → `spi_w_block` drops the next cycle, `err=1`, `busy=0`, no further writes until `reset`.
- `reset` asserted during WAIT → next cycle in IDLE with all outputs at reset values. A new `start` writes correctly.
